// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler for the 16 x DATA_W register file: round-robin arbitration of ALU and
// load write-backs onto the single write port, plus a busy scoreboard that stalls decode on hazards.
module rf_wb_scheduler #(
    parameter int unsigned DATA_W      = 16,
    parameter bit          ZERO_REG_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              alu_valid,
    input  logic [3:0]        alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,

    input  logic              mem_valid,
    input  logic [3:0]        mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,

    input  logic              issue_valid,
    input  logic [3:0]        issue_reg,
    input  logic              src1_use,
    input  logic [3:0]        src1_reg,
    input  logic              src2_use,
    input  logic [3:0]        src2_reg,
    output logic              stall,

    output logic [3:0]        rf_dst_reg,
    output logic              rf_write,
    output logic [DATA_W-1:0] rf_dst_data,
    output logic [15:0]       busy
);

    localparam int unsigned REG_W    = 4;
    localparam int unsigned NUM_REGS = 16;

    // Priority pointer: 0 favours ALU, 1 favours MEM when both request.
    logic                rr;
    logic                rr_next;
    logic                grant_alu;
    logic                grant_mem;
    logic                handshake;
    logic [REG_W-1:0]    sel_reg;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_drop;
    logic                issue_take;
    logic                issue_marks;
    logic [NUM_REGS-1:0] busy_next;
    logic                rf_write_next;
    logic [REG_W-1:0]    rf_dst_reg_next;
    logic [DATA_W-1:0]   rf_dst_data_next;

    // Arbitration and write-port selection.
    always_comb begin
        grant_alu = alu_valid & (~mem_valid | ~rr);
        grant_mem = mem_valid & (~alu_valid | rr);
        handshake = grant_alu | grant_mem;
        alu_ready = grant_alu;
        mem_ready = grant_mem;

        sel_reg  = grant_mem ? mem_reg  : alu_reg;
        sel_data = grant_mem ? mem_data : alu_data;
        sel_drop = ZERO_REG_EN && (sel_reg == REG_W'(0));

        rr_next = rr;
        if (grant_alu) begin
            rr_next = 1'b1;
        end else if (grant_mem) begin
            rr_next = 1'b0;
        end

        rf_write_next    = handshake & ~sel_drop;
        rf_dst_reg_next  = rf_dst_reg;
        rf_dst_data_next = rf_dst_data;
        if (handshake) begin
            rf_dst_reg_next  = sel_reg;
            rf_dst_data_next = sel_data;
        end
    end

    // Hazard detection; no bypass, so the register being written this cycle still stalls.
    always_comb begin
        stall = issue_valid & ((src1_use & busy[src1_reg]) |
                               (src2_use & busy[src2_reg]) |
                               busy[issue_reg]);
        issue_take  = issue_valid & ~stall;
        issue_marks = issue_take & ~(ZERO_REG_EN && (issue_reg == REG_W'(0)));

        busy_next = busy;
        if (rf_write) begin
            busy_next[rf_dst_reg] = 1'b0;
        end
        if (issue_marks) begin
            busy_next[issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr          <= 1'b0;
            rf_write    <= 1'b0;
            rf_dst_reg  <= '0;
            rf_dst_data <= '0;
            busy        <= '0;
        end else begin
            rr          <= rr_next;
            rf_write    <= rf_write_next;
            rf_dst_reg  <= rf_dst_reg_next;
            rf_dst_data <= rf_dst_data_next;
            busy        <= busy_next;
        end
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: arbitration, write stage, scoreboard and reset behaviour.
module tb_rf_wb_scheduler;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_reg;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_reg;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        issue_valid;
    logic [3:0]  issue_reg;
    logic        src1_use;
    logic [3:0]  src1_reg;
    logic        src2_use;
    logic [3:0]  src2_reg;
    logic        stall;
    logic [3:0]  rf_dst_reg;
    logic        rf_write;
    logic [15:0] rf_dst_data;
    logic [15:0] busy;

    int errors = 0;
    int checks = 0;

    rf_wb_scheduler #(.DATA_W(16), .ZERO_REG_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .src1_use(src1_use), .src1_reg(src1_reg), .src2_use(src2_use), .src2_reg(src2_reg),
        .stall(stall),
        .rf_dst_reg(rf_dst_reg), .rf_write(rf_write), .rf_dst_data(rf_dst_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_reg = 0; alu_data = 0;
        mem_valid = 0; mem_reg = 0; mem_data = 0;
        issue_valid = 0; issue_reg = 0;
        src1_use = 0; src1_reg = 0; src2_use = 0; src2_reg = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #3;
        checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL reset_rf_write got=%b exp=0", rf_write); end
        checks++; if (rf_dst_reg !== 4'd0) begin errors++; $display("FAIL reset_dst_reg got=%h exp=0", rf_dst_reg); end
        checks++; if (rf_dst_data !== 16'h0) begin errors++; $display("FAIL reset_dst_data got=%h exp=0", rf_dst_data); end
        checks++; if (busy !== 16'h0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
        #9 rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        alu_valid = 1; alu_reg = 4'd3; alu_data = 16'hBEEF;
        #1;
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL single_ready got=%b%b exp=10", alu_ready, mem_ready); end
        tick();
        alu_valid = 0;
        checks++; if (rf_write !== 1'b1) begin errors++; $display("FAIL single_write got=%b exp=1", rf_write); end
        checks++; if (rf_dst_reg !== 4'd3) begin errors++; $display("FAIL single_dst_reg got=%h exp=3", rf_dst_reg); end
        checks++; if (rf_dst_data !== 16'hBEEF) begin errors++; $display("FAIL single_dst_data got=%h exp=beef", rf_dst_data); end
        tick();
        checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL single_write_drop got=%b exp=0", rf_write); end
        checks++; if (rf_dst_reg !== 4'd3 || rf_dst_data !== 16'hBEEF) begin errors++; $display("FAIL single_hold got=%h/%h exp=3/beef", rf_dst_reg, rf_dst_data); end
    endtask

    // Reset asserted between edges while a write is in flight and R4 is busy.
    task automatic test_reset_mid();
        alu_valid = 1; alu_reg = 4'd4; alu_data = 16'h4444;
        issue_valid = 1; issue_reg = 4'd4;
        tick();
        idle_inputs();
        checks++; if (rf_write !== 1'b1 || busy !== 16'h0010) begin errors++; $display("FAIL midrst_pre got=%b/%h exp=1/0010", rf_write, busy); end
        #2 rst = 1'b0;
        #1;
        checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL midrst_write got=%b exp=0", rf_write); end
        checks++; if (busy !== 16'h0000) begin errors++; $display("FAIL midrst_busy got=%h exp=0000", busy); end
        #2 rst = 1'b1;
        tick();
    endtask

    // Both requesters valid right after reset: ALU must win first (rr back to 0).
    task automatic test_contention();
        logic [3:0] exp_reg;
        alu_valid = 1; alu_reg = 4'd1; alu_data = 16'h1111;
        mem_valid = 1; mem_reg = 4'd2; mem_data = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (alu_ready !== (i % 2 == 0) || mem_ready !== (i % 2 == 1)) begin
                errors++; $display("FAIL contention_grant%0d got=%b%b exp=%b%b", i, alu_ready, mem_ready, (i % 2 == 0), (i % 2 == 1));
            end
            tick();
            exp_reg = (i % 2 == 0) ? 4'd1 : 4'd2;
            checks++; if (rf_write !== 1'b1 || rf_dst_reg !== exp_reg) begin
                errors++; $display("FAIL contention_write%0d got=%b/%h exp=1/%h", i, rf_write, rf_dst_reg, exp_reg);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_raw();
        issue_valid = 1; issue_reg = 4'd5;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_issue_stall got=%b exp=0", stall); end
        tick();
        checks++; if (busy !== 16'h0020) begin errors++; $display("FAIL raw_busy_set got=%h exp=0020", busy); end
        issue_reg = 4'd6; src1_use = 1; src1_reg = 4'd5;
        mem_valid = 1; mem_reg = 4'd5; mem_data = 16'h5555;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall got=%b exp=1", stall); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL raw_mem_ready got=%b exp=1", mem_ready); end
        tick();
        mem_valid = 0;
        #1;
        checks++; if (rf_write !== 1'b1 || rf_dst_reg !== 4'd5 || rf_dst_data !== 16'h5555) begin
            errors++; $display("FAIL raw_write got=%b/%h/%h exp=1/5/5555", rf_write, rf_dst_reg, rf_dst_data);
        end
        checks++; if (stall !== 1'b1 || busy !== 16'h0020) begin errors++; $display("FAIL raw_no_bypass got=%b/%h exp=1/0020", stall, busy); end
        tick();
        checks++; if (busy !== 16'h0000 || stall !== 1'b0) begin errors++; $display("FAIL raw_release got=%h/%b exp=0000/0", busy, stall); end
        tick();
        idle_inputs();
        checks++; if (busy !== 16'h0040) begin errors++; $display("FAIL raw_taken got=%h exp=0040", busy); end
        alu_valid = 1; alu_reg = 4'd6; alu_data = 16'h6666;
        tick();
        alu_valid = 0;
        tick();
        checks++; if (busy !== 16'h0000) begin errors++; $display("FAIL raw_clear6 got=%h exp=0000", busy); end
    endtask

    task automatic test_waw_r0();
        issue_valid = 1; issue_reg = 4'd5;
        tick();
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall got=%b exp=1", stall); end
        tick();
        issue_valid = 0;
        checks++; if (busy !== 16'h0020) begin errors++; $display("FAIL waw_busy got=%h exp=0020", busy); end
        mem_valid = 1; mem_reg = 4'd0; mem_data = 16'hDEAD;
        #1;
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got=%b exp=1", mem_ready); end
        tick();
        mem_valid = 0;
        checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL r0_write got=%b exp=0", rf_write); end
        issue_valid = 1; issue_reg = 4'd0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_issue_stall got=%b exp=0", stall); end
        tick();
        issue_valid = 0;
        checks++; if (busy !== 16'h0020) begin errors++; $display("FAIL r0_busy got=%h exp=0020", busy); end
        alu_valid = 1; alu_reg = 4'd5; alu_data = 16'h0005;
        tick();
        alu_valid = 0;
        tick();
        checks++; if (busy !== 16'h0000) begin errors++; $display("FAIL waw_clear got=%h exp=0000", busy); end
    endtask

    task automatic test_simul();
        issue_valid = 1; issue_reg = 4'd7;
        tick();
        issue_valid = 0;
        checks++; if (busy !== 16'h0080) begin errors++; $display("FAIL simul_set7 got=%h exp=0080", busy); end
        alu_valid = 1; alu_reg = 4'd7; alu_data = 16'h7777;
        tick();
        alu_valid = 0;
        issue_valid = 1; issue_reg = 4'd9;
        #1;
        checks++; if (rf_write !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL simul_cycle got=%b/%b exp=1/0", rf_write, stall); end
        tick();
        issue_valid = 0;
        checks++; if (busy !== 16'h0200) begin errors++; $display("FAIL simul_busy got=%h exp=0200", busy); end
        alu_valid = 1; alu_reg = 4'd9; alu_data = 16'h9999;
        tick();
        alu_valid = 0;
        tick();
    endtask

    // One write per cycle from a single continuously valid requester.
    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_reg = 4'(10 + i); alu_data = 16'(16'hA000 + i);
            #1;
            checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got=%b exp=1", i, alu_ready); end
            tick();
            checks++; if (rf_write !== 1'b1 || rf_dst_reg !== 4'(10 + i) || rf_dst_data !== 16'(16'hA000 + i)) begin
                errors++; $display("FAIL b2b_write%0d got=%b/%h/%h exp=1/%h/%h", i, rf_write, rf_dst_reg, rf_dst_data, 4'(10 + i), 16'(16'hA000 + i));
            end
        end
        alu_valid = 0;
        tick();
        checks++; if (rf_write !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b exp=0", rf_write); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_contention();
        test_raw();
        test_waw_r0();
        test_simul();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Write-back scheduler and scoreboard for the 16 x 16-bit register file. It shares the register file's single write port between two write-back requesters: ALU and memory load. It uses round-robin arbitration and drives the port's destination, enable and data inputs from a registered stage. It also tracks which registers have an outstanding write in a busy scoreboard and raises a stall when a decoded instruction's sources or destination are busy.

## Interface
- DATA_W, 16, write data width; must match register file data width
- ZERO_REG_EN, 1, when 1 register 0 is read-only: writes to it are accepted and dropped, issues to it never mark busy
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- alu_valid  in  1  ALU write-back request
- alu_reg  in  4  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load write-back request
- mem_reg  in  4  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request accepted this cycle
- issue_valid  in  1  decode issues an instruction that will write issue_reg
- issue_reg  in  4  destination of issuing instruction
- src1_use, src2_use  in  1 each  instruction reads src1_reg / src2_reg
- src1_reg, src2_reg  in  4 each  source registers of decoding instruction
- stall  out  1  decode must hold; issue not taken
- rf_dst_reg  out  4  to register file DstReg
- rf_write  out  1  to register file WriteReg
- rf_dst_data  out  DATA_W  to register file DstData
- busy  out  16  scoreboard; bit n = write to Rn outstanding

## Operation
- **Arbitration:** combinational from valids and the 1-bit priority pointer `rr` (0 = ALU, 1 = MEM).
  - Only one valid: it is granted.
  - Both valid: the side named by `rr` is granted; the other sees ready=0 and must hold reg/data stable.
  - At most one ready is high per cycle. Neither is high when no valid is asserted.
- **Pointer:** after any grant, `rr` points to the non-granted side. With no grant, `rr` is unchanged.
- **Write stage:**
  - On a handshake, the granted reg and data are registered into rf_dst_reg and rf_dst_data. rf_write is set to 1, except it is 0 when reg=0 and ZERO_REG_EN=1.
  - With no handshake, rf_write goes to 0. rf_dst_reg and rf_dst_data hold their last values.
- **Scoreboard set:** on a taken issue, busy[issue_reg] is set. A taken issue is issue_valid=1 with stall=0. Register 0 is never set when ZERO_REG_EN=1.
- **Scoreboard clear:** busy[rf_dst_reg] is cleared in each cycle with rf_write=1. A write to a non-busy register is legal and clears nothing.
- **Stall:** stall = issue_valid & (src1_use & busy[src1_reg] | src2_use & busy[src2_reg] | busy[issue_reg]).
  - The busy[issue_reg] term blocks write-after-write hazards.
  - There is no bypass: a register being written in the current cycle still counts as busy.
- **Same-register collision:** a set and a clear of the same register in one cycle cannot occur, because issue to a busy register stalls.
  - Set and clear of different registers in the same cycle both take effect.

## Timing
- **Reset values:** rf_write=0, rf_dst_reg=0, rf_dst_data=0, busy=0, rr=0.
  - alu_ready, mem_ready and stall follow their combinational equations from these values.
- **Latency:** handshake in cycle N, then rf_write=1 in cycle N+1. The register file captures the data at the end of N+1 and it is readable in N+2.
- **Scoreboard:** a busy bit clears at the end of N+1 and stall drops in N+2 for a waiting reader.
  - Result: a dependent instruction reads the new value in N+2.
- **Throughput:** one write per cycle sustained.
  - With both requesters continuously valid, grants strictly alternate: ALU, MEM, ALU, ...
- **Reset mid-operation:** asynchronous assertion immediately drops rf_write and clears busy.
  - The in-flight write is lost. Requesters must be reset by the same signal.
- **Ready timing:** ready depends only on both valids and `rr`. Requesters must not make valid depend on ready.

## Test plan
- **Reset:** assert rst=0 mid-write (rf_write=1, busy=16'h0010) -> rf_write=0 and busy=16'h0000 immediately, before the next clock edge; after release, rr=0.
- **Single writer:** alu_valid=1, alu_reg=3, alu_data=16'hBEEF for 1 cycle -> alu_ready=1 same cycle; next cycle rf_write=1, rf_dst_reg=3, rf_dst_data=16'hBEEF; following cycle rf_write=0.
- **Contention:** alu and mem both valid for 4 cycles after reset (regs 1, 2) -> grants ALU, MEM, ALU, MEM; never both ready in one cycle.
- **Scoreboard RAW:** issue reg 5 (busy[5]=1) -> next instruction with src1_reg=5 stalls. MEM writes R5 in cycle N -> rf_write in N+1, busy[5]=0 and stall=0 in N+2.
- **WAW and R0:** issue reg 5 while busy[5]=1 -> stall=1 and busy unchanged. mem_reg=0 handshake -> mem_ready=1, rf_write stays 0. Issue reg 0 -> busy[0] stays 0.
- **Simultaneous set/clear:** in the cycle rf_write=1 for R7 (busy[7]=1), issue reg 9 with no sources -> stall=0, next cycle busy[7]=0 and busy[9]=1.
